sipo: RTL and testbench

Serial-in, parallel-out shift register. Captures one serial bit per rising clock edge and presents the most recent WIDTH bits as a parallel word. Used as the deserialising front end wherever a single-bit stream must be assembled into bytes for downstream parallel logic.

---
 rtl/sipo.sv | 20 ++
 tb/tb_sipo.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sipo.sv
// sipo: serial-in, parallel-out shift register with LSB-in shifting by default.
// Defining SIPO_MSB_IN_EN makes new bits enter at the MSB and shift right.
module sipo #(
  parameter int WIDTH = 8
) (
  input  logic             data,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] op
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk)
    if (rst) sr <= '0;
`ifdef SIPO_MSB_IN_EN
    else sr <= {data, sr[WIDTH-1:1]};
`else
    else sr <= {sr[WIDTH-2:0], data};
`endif
  assign op = sr;
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: directed self-checking bench for sipo in either shift direction.
module tb_sipo;
  logic       data = 1'b0;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] op;
  int         passed = 0;
  int         total = 0;

  sipo #(.WIDTH(8)) dut (.data(data), .clk(clk), .rst(rst), .op(op));

  always #5 clk = ~clk;

`ifdef SIPO_MSB_IN_EN
  localparam logic [7:0] E_WORD = 8'b01001101, E_FIRST = 8'b10000000;
  localparam logic [7:0] E_P3 = 8'b11100000, E_P4 = 8'b01110000;
  localparam logic [7:0] E_OVF = 8'h7F, E_M4 = 8'hF0, E_M1 = 8'h80;
`else
  localparam logic [7:0] E_WORD = 8'b10110010, E_FIRST = 8'b00000001;
  localparam logic [7:0] E_P3 = 8'b00000111, E_P4 = 8'b00001110;
  localparam logic [7:0] E_OVF = 8'hFE, E_M4 = 8'h0F, E_M1 = 8'h01;
`endif

  task automatic step(input logic d, input logic r);
    @(negedge clk);
    data = d;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1);
    total++;
    if (op !== 8'h00) $display("FAIL reset_edge1 op=%h exp=00", op); else passed++;
    step(1'b1, 1'b1);
    total++;
    if (op !== 8'h00) $display("FAIL reset_held op=%h exp=00", op); else passed++;
  endtask

  task automatic test_full_word;
    logic [7:0] bits;
    bits = 8'b10110010;
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step(bits[i], 1'b0);
      if (i == 7) begin
        total++;
        if (op !== E_FIRST) $display("FAIL first_bit op=%b exp=%b", op, E_FIRST); else passed++;
      end
    end
    total++;
    if (op !== E_WORD) $display("FAIL full_word op=%b exp=%b", op, E_WORD); else passed++;
  endtask

  task automatic test_partial;
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    total++;
    if (op !== E_P3) $display("FAIL partial3 op=%b exp=%b", op, E_P3); else passed++;
    step(1'b0, 1'b0);
    total++;
    if (op !== E_P4) $display("FAIL partial4 op=%b exp=%b", op, E_P4); else passed++;
  endtask

  task automatic test_overflow;
    step(1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0);
      if (i >= 8) begin
        total++;
        if (op !== 8'hFF) $display("FAIL overflow_ones%0d op=%h exp=ff", i, op); else passed++;
      end
    end
    step(1'b0, 1'b0);
    total++;
    if (op !== E_OVF) $display("FAIL overflow_zero op=%h exp=%h", op, E_OVF); else passed++;
  endtask

  task automatic test_mid_reset;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    total++;
    if (op !== E_M4) $display("FAIL mid_pre op=%h exp=%h", op, E_M4); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (op !== E_M4) $display("FAIL reset_not_async op=%h exp=%h", op, E_M4); else passed++;
    @(posedge clk);
    #1;
    total++;
    if (op !== 8'h00) $display("FAIL mid_reset op=%h exp=00", op); else passed++;
    step(1'b1, 1'b0);
    total++;
    if (op !== E_M1) $display("FAIL mid_restart op=%h exp=%h", op, E_M1); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bits;
    logic [7:0] exp;
    bits = 8'b01101001;
    step(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(bits[i], 1'b0);
`ifdef SIPO_MSB_IN_EN
    exp = 8'b10010110;
`else
    exp = 8'b01101001;
`endif
    total++;
    if (op !== exp) $display("FAIL b2b_word1 op=%b exp=%b", op, exp); else passed++;
    bits = 8'b11000101;
    for (int i = 7; i >= 0; i--) step(bits[i], 1'b0);
`ifdef SIPO_MSB_IN_EN
    exp = 8'b10100011;
`else
    exp = 8'b11000101;
`endif
    total++;
    if (op !== exp) $display("FAIL b2b_word2 op=%b exp=%b", op, exp); else passed++;
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_partial;
    test_overflow;
    test_mid_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
